// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: shared constants and types for the EX-stage ALU block.
//   - funct field encodings (FN_*)
//   - 4-bit ALU control encodings (CTL_*)
//   - main-control ALUOp encodings (ALUOP_*)
//   - FSM state type (ST_DIV exists only when ALU_EXEC_DIV_EN is defined)
package alu_exec_pkg;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  localparam logic [3:0] CTL_AND   = 4'b0000;
  localparam logic [3:0] CTL_OR    = 4'b0001;
  localparam logic [3:0] CTL_ADD   = 4'b0010;
  localparam logic [3:0] CTL_SLL   = 4'b0100;
  localparam logic [3:0] CTL_SUB   = 4'b0110;
  localparam logic [3:0] CTL_SLT   = 4'b0111;
  localparam logic [3:0] CTL_MULTU = 4'b1000;
  localparam logic [3:0] CTL_DIVU  = 4'b1001;
  localparam logic [3:0] CTL_MFHI  = 4'b1010;
  localparam logic [3:0] CTL_MFLO  = 4'b1011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1
`ifdef ALU_EXEC_DIV_EN
    ,
    ST_DIV  = 2'd2
`endif
  } state_t;

endpackage

// File: rtl/alu_exec_decode.sv
// alu_exec_decode: combinational funct/ALUOp -> 4-bit ALU control decoder.
//   alu_op  : main-control ALUOp
//   funct   : instruction funct field
//   alu_ctl : decoded control
// Optional macro ALU_EXEC_DIV_EN adds the divu decode; otherwise divu
// falls into the default (and) like any unknown funct.
module alu_exec_decode
  import alu_exec_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctl
);

  always_comb begin
    alu_ctl = CTL_AND;
    if (alu_op == ALUOP_ADD) begin
      alu_ctl = CTL_ADD;
    end else if (alu_op[0]) begin
      // ALUOp 01 and 11 both mean subtract (branch compare)
      alu_ctl = CTL_SUB;
    end else begin
      case (funct)
        FN_ADD:   alu_ctl = CTL_ADD;
        FN_SUB:   alu_ctl = CTL_SUB;
        FN_AND:   alu_ctl = CTL_AND;
        FN_OR:    alu_ctl = CTL_OR;
        FN_SLT:   alu_ctl = CTL_SLT;
        FN_SLL:   alu_ctl = CTL_SLL;
        FN_MULTU: alu_ctl = CTL_MULTU;
        FN_MFHI:  alu_ctl = CTL_MFHI;
        FN_MFLO:  alu_ctl = CTL_MFLO;
`ifdef ALU_EXEC_DIV_EN
        FN_DIVU:  alu_ctl = CTL_DIVU;
`endif
        default:  alu_ctl = CTL_AND;
      endcase
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage block with decode, registered single-cycle ALU,
// iterative shift-add multiplier and HI/LO registers.
//   clk, reset (async, active high)
//   in_valid/in_ready : operation handshake; in_ready low during multi-cycle ops
//   instruccion, ALUOp, shamt, op_a, op_b : operation inputs
//   out_valid : one-cycle result pulse; result/zero registered with it
//   alu_ctl   : control of the last accepted op
//   stall     : ~in_ready, to the hazard unit
// Optional macro ALU_EXEC_DIV_EN adds an iterative restoring divu.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       instruccion,
  input  logic [1:0]       ALUOp,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [3:0]       alu_ctl,
  output logic             stall
);

  localparam int CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               out_valid_q, out_valid_d;
  logic [3:0]         alu_ctl_q, alu_ctl_d;
  // mcand holds multiplicand (or divisor); mplier holds multiplier (or
  // dividend, which turns into the quotient as it shifts).
  logic [WIDTH-1:0]   mcand_q, mcand_d, mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;

  logic [3:0]         dec_ctl;
  logic               accept;
  logic [WIDTH-1:0]   alu_out;
  logic [WIDTH:0]     mul_sum;

  alu_exec_decode u_decode (
    .alu_op  (ALUOp),
    .funct   (instruccion),
    .alu_ctl (dec_ctl)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign stall     = ~in_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign alu_ctl   = alu_ctl_q;

  always_comb begin
    alu_out = '0;
    case (dec_ctl)
      CTL_ADD:  alu_out = op_a + op_b;
      CTL_SUB:  alu_out = op_a - op_b;
      CTL_AND:  alu_out = op_a & op_b;
      CTL_OR:   alu_out = op_a | op_b;
      CTL_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      CTL_SLL:  alu_out = op_b << shamt;
      CTL_MFHI: alu_out = hi_q;
      CTL_MFLO: alu_out = lo_q;
      default:  alu_out = '0;
    endcase
  end

  // Right-shifting accumulator: add the multiplicand into the upper half
  // when the current multiplier bit is set, then shift everything right.
  // After WIDTH steps acc holds the full product.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (mplier_q[0] ? mcand_q : {WIDTH{1'b0}})};

`ifdef ALU_EXEC_DIV_EN
  // Restoring division; the partial remainder lives in acc_q[WIDTH-1:0].
  // A zero divisor naturally yields quotient all ones and remainder op_a.
  logic [WIDTH:0]     rem_shift, div_diff;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_next;
  assign rem_shift = {acc_q[WIDTH-1:0], mplier_q[WIDTH-1]};
  assign div_diff  = rem_shift - {1'b0, mcand_q};
  assign q_bit     = ~div_diff[WIDTH];
  assign rem_next  = q_bit ? div_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = 1'b0;
    alu_ctl_d   = alu_ctl_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          alu_ctl_d = dec_ctl;
          case (dec_ctl)
            CTL_MULTU: begin
              mcand_d  = op_a;
              mplier_d = op_b;
              acc_d    = '0;
              cnt_d    = '0;
              state_d  = ST_MUL;
            end
`ifdef ALU_EXEC_DIV_EN
            CTL_DIVU: begin
              mcand_d  = op_b;
              mplier_d = op_a;
              acc_d    = '0;
              cnt_d    = '0;
              state_d  = ST_DIV;
            end
`endif
            default: begin
              result_d    = alu_out;
              zero_d      = (alu_out == '0);
              out_valid_d = 1'b1;
            end
          endcase
        end
      end
      ST_MUL: begin
        acc_d    = {mul_sum, acc_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNTW'(1);
        if (cnt_q == CNT_LAST) begin
          hi_d        = acc_d[2*WIDTH-1:WIDTH];
          lo_d        = acc_d[WIDTH-1:0];
          result_d    = acc_d[WIDTH-1:0];
          zero_d      = (acc_d[WIDTH-1:0] == '0);
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = ST_IDLE;
        end
      end
`ifdef ALU_EXEC_DIV_EN
      ST_DIV: begin
        acc_d    = {acc_q[2*WIDTH-1:WIDTH], rem_next};
        mplier_d = {mplier_q[WIDTH-2:0], q_bit};
        cnt_d    = cnt_q + CNTW'(1);
        if (cnt_q == CNT_LAST) begin
          hi_d        = rem_next;
          lo_d        = mplier_d;
          result_d    = mplier_d;
          zero_d      = (mplier_d == '0);
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
      alu_ctl_q   <= CTL_AND;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      alu_ctl_q   <= alu_ctl_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed + randomized bench for alu_exec_unit against a
// behavioural model (plain arithmetic on 64-bit values, HI/LO variables).
// Honours ALU_EXEC_DIV_EN when defined.
module tb_alu_exec_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [5:0]   instruccion;
  logic [1:0]   ALUOp;
  logic [4:0]   shamt;
  logic [W-1:0] op_a, op_b;
  logic         out_valid;
  logic [W-1:0] result;
  logic         zero;
  logic [3:0]   alu_ctl;
  logic         stall;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(W), .SHW(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instruccion (instruccion),
    .ALUOp       (ALUOp),
    .shamt       (shamt),
    .op_a        (op_a),
    .op_b        (op_b),
    .out_valid   (out_valid),
    .result      (result),
    .zero        (zero),
    .alu_ctl     (alu_ctl),
    .stall       (stall)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_ctl(input logic [1:0] op, input logic [5:0] fn);
    if (op == 2'b00) return 4'b0010;
    if (op[0]) return 4'b0110;
    case (fn)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      6'b000000: return 4'b0100;
      6'b011001: return 4'b1000;
      6'b010000: return 4'b1010;
      6'b010010: return 4'b1011;
`ifdef ALU_EXEC_DIV_EN
      6'b011011: return 4'b1001;
`endif
      default:   return 4'b0000;
    endcase
  endfunction

  function automatic logic [W-1:0] ref_single(input logic [3:0] ctl, input logic [W-1:0] a,
                                              input logic [W-1:0] b, input logic [4:0] sh);
    logic [63:0] wide;
    case (ctl)
      4'b0010: begin wide = 64'(a) + 64'(b); return wide[W-1:0]; end
      4'b0110: begin wide = 64'(a) + 64'(~b) + 64'd1; return wide[W-1:0]; end
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0111: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'b0100: begin wide = 64'(b) * (64'd1 << sh); return wide[W-1:0]; end
      4'b1010: return m_hi;
      4'b1011: return m_lo;
      default: return '0;
    endcase
  endfunction

  // Issue one op and check its outcome. If poke is set, an add is offered
  // throughout a multi-cycle op and must be ignored.
  task automatic do_op(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
    logic [3:0]   ctl;
    logic [W-1:0] exp_r;
    logic [63:0]  prod;
    ctl = ref_ctl(op, fn);
    ALUOp = op; instruccion = fn; shamt = sh; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    check("alu_ctl", alu_ctl, ctl);
    if (ctl == 4'b1000 || ctl == 4'b1001) begin
      check("multi_accept", {in_ready, out_valid, stall}, 3'b001);
      if (poke) begin
        ALUOp = 2'b00; op_a = 32'd1; op_b = 32'd1; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      if (ctl == 4'b1000) begin
        prod = 64'(a) * 64'(b);
        m_hi = prod[63:32]; m_lo = prod[31:0];
      end else if (b == 0) begin
        m_lo = '1; m_hi = a;
      end else begin
        m_lo = a / b; m_hi = a % b;
      end
      for (int i = 1; i < W; i++) begin
        @(posedge clk); #1;
        check("multi_busy", {in_ready, out_valid, stall}, 3'b001);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("multi_done_valid", {in_ready, out_valid, stall}, 3'b110);
      check("multi_result", result, m_lo);
      check("multi_zero", zero, (m_lo == 0));
      check("multi_ctl_held", alu_ctl, ctl);
      exp_r = m_lo;
    end else begin
      exp_r = ref_single(ctl, a, b, sh);
      check("single_valid", {in_ready, out_valid, stall}, 3'b110);
      check("single_result", result, exp_r);
      check("single_zero", zero, (exp_r == 0));
      in_valid = 1'b0;
    end
    $display("op aluop=%b funct=%b ctl=%b a=%h b=%h sh=%0d -> result=%h", op, fn, ctl, a, b, sh, exp_r);
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("idle_no_valid", out_valid, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, {in_ready, stall, out_valid}, 3'b100);
    check({tag, "_result"}, result, 32'd0);
    check({tag, "_zero"}, zero, 1'b1);
    check({tag, "_ctl"}, alu_ctl, 4'b0000);
  endtask

  logic [5:0] fn_tab [12];

  initial begin
    int seen;
    reset = 1'b1; in_valid = 1'b0; instruccion = '0; ALUOp = '0; shamt = '0; op_a = '0; op_b = '0;
    #2;
    check_reset_state("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // directed
    do_op(2'b10, 6'b100010, 5'd0, 32'd5, 32'd7, 1'b0);
    do_op(2'b10, 6'b101010, 5'd0, 32'hFFFFFFFF, 32'd1, 1'b0);
    do_op(2'b10, 6'b000000, 5'd31, 32'd0, 32'd1, 1'b0);
    idle_cycle();
    do_op(2'b10, 6'b011001, 5'd0, 32'hFFFFFFFF, 32'd2, 1'b1);
    do_op(2'b00, 6'b100000, 5'd0, 32'd1, 32'd1, 1'b0);
    do_op(2'b10, 6'b010000, 5'd0, 32'd0, 32'd0, 1'b0);
    do_op(2'b10, 6'b010010, 5'd0, 32'd0, 32'd0, 1'b0);
    do_op(2'b01, 6'b100101, 5'd0, 32'd10, 32'd10, 1'b0);
    do_op(2'b11, 6'b000000, 5'd0, 32'd3, 32'd9, 1'b0);
    do_op(2'b10, 6'b111111, 5'd0, 32'hF0, 32'h3C, 1'b0);
    do_op(2'b10, 6'b011011, 5'd0, 32'd7, 32'd2, 1'b0);
    do_op(2'b10, 6'b010000, 5'd0, 32'd0, 32'd0, 1'b0);
    do_op(2'b10, 6'b011011, 5'd0, 32'd9, 32'd0, 1'b0);
    do_op(2'b10, 6'b010000, 5'd0, 32'd0, 32'd0, 1'b0);
    do_op(2'b10, 6'b010010, 5'd0, 32'd0, 32'd0, 1'b0);
    idle_cycle();

    // reset in the middle of multu 3*4 (cnt==10)
    ALUOp = 2'b10; instruccion = 6'b011001; op_a = 32'd3; op_b = 32'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_reset_state("midmul_reset");
    m_hi = '0; m_lo = '0;
    #1;
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("aborted_no_output", seen, 0);
    $display("op reset during multu a=3 b=4 -> aborted");
    do_op(2'b10, 6'b010010, 5'd0, 32'd0, 32'd0, 1'b0);

    // randomized
    fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000,
               6'b011001, 6'b011011, 6'b010000, 6'b010010, 6'b111111, 6'b000001};
    for (int n = 0; n < 60; n++) begin
      logic [1:0]   r_op;
      logic [5:0]   r_fn;
      logic [W-1:0] r_a, r_b;
      r_op = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
      r_fn = fn_tab[$urandom_range(0, 11)];
      if (r_fn == 6'b000001) r_fn = 6'($urandom);
      r_a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      r_b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      if ($urandom_range(0, 7) == 0) r_b = r_a;
      do_op(r_op, r_fn, 5'($urandom), r_a, r_b, 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
